// File: rtl/wbr_out_if.sv
// Output wrapper boundary register signal bundle.
// Optional safe-state input is present only when WBR_OUT_SAFE_EN is defined.
interface wbr_out_if;
   logic       WPSI4;
   logic       Core_VALID;
   logic [7:0] CoreOUT_DOUT;
   logic       wse_outputs;
   logic       capture_outputs;
   logic       update_outputs;
   logic       test_mode;
`ifdef WBR_OUT_SAFE_EN
   logic       safe_state;
`endif
   logic       VALID;
   logic [7:0] DOUT;
   logic       WPSO4;
   logic       shift_done;

   // Boundary-register side.
   modport slave (
`ifdef WBR_OUT_SAFE_EN
      input  safe_state,
`endif
      input  WPSI4,
      input  Core_VALID,
      input  CoreOUT_DOUT,
      input  wse_outputs,
      input  capture_outputs,
      input  update_outputs,
      input  test_mode,
      output VALID,
      output DOUT,
      output WPSO4,
      output shift_done
   );

   // Controller / core side.
   modport master (
`ifdef WBR_OUT_SAFE_EN
      output safe_state,
`endif
      output WPSI4,
      output Core_VALID,
      output CoreOUT_DOUT,
      output wse_outputs,
      output capture_outputs,
      output update_outputs,
      output test_mode,
      input  VALID,
      input  DOUT,
      input  WPSO4,
      input  shift_done
   );
endinterface

// File: rtl/wbr_out.sv
// Output wrapper boundary register: 9 cells (cell 0 = VALID, cells 1..8 = DOUT[7:0]),
// each with a shift flop and an update flop.
// Optional feature: define WBR_OUT_SAFE_EN to add a safe_state pin-forcing input.
module wbr_out (
   input logic     CLK,
   input logic     resetn,
   wbr_out_if.slave bus
);

   // The operation is chosen fresh every cycle from the control inputs, so the
   // state is decoded combinationally and acted upon at the next rising edge.
   typedef enum logic [1:0] {StIdle, StCapture, StShift, StUpdate} state_e;

   localparam logic [3:0] ShiftLen = 4'd9;

   state_e     state;
   logic [8:0] sr_q, sr_d;
   logic [8:0] up_q, up_d;
   logic [3:0] cnt_q, cnt_d;

   // Operation select: capture > shift > update > idle.
   always_comb begin
      state = StIdle;
      if (bus.capture_outputs) begin
         state = StCapture;
      end else if (bus.wse_outputs) begin
         state = StShift;
      end else if (bus.update_outputs) begin
         state = StUpdate;
      end
   end

   // Next-state for shift stage, update stage and shift counter.
   always_comb begin
      sr_d  = sr_q;
      up_d  = up_q;
      cnt_d = cnt_q;
      unique case (state)
         StCapture: begin
            sr_d  = {bus.CoreOUT_DOUT, bus.Core_VALID};
            cnt_d = 4'd0;
         end
         StShift: begin
            sr_d = {sr_q[7:0], bus.WPSI4};
            if (cnt_q != ShiftLen) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StUpdate: begin
            up_d = sr_q;
         end
         default: ;
      endcase
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         sr_q  <= '0;
         up_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         up_q  <= up_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.WPSO4      = sr_q[8];
   assign bus.shift_done = (cnt_q == ShiftLen);

   // Pin drive: functional pass-through or update stage, optionally forced safe.
   always_comb begin
      if (bus.test_mode) begin
         bus.VALID = up_q[0];
         bus.DOUT  = up_q[8:1];
      end else begin
         bus.VALID = bus.Core_VALID;
         bus.DOUT  = bus.CoreOUT_DOUT;
      end
`ifdef WBR_OUT_SAFE_EN
      if (bus.safe_state) begin
         bus.VALID = 1'b0;
         bus.DOUT  = 8'h00;
      end
`endif
   end

endmodule

// File: tb/tb_wbr_out.sv
// Directed self-checking bench for wbr_out.
module tb_wbr_out;

   logic CLK;
   logic resetn;
   int   checks;
   int   failures;

   wbr_out_if bus ();

   wbr_out dut (
      .CLK    (CLK),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one rising edge; inputs are set beforehand, outputs read 1 unit after.
   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_ctrl();
      bus.capture_outputs = 1'b0;
      bus.wse_outputs     = 1'b0;
      bus.update_outputs  = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle_ctrl();
      bus.WPSI4        = 1'b0;
      bus.Core_VALID   = 1'b1;
      bus.CoreOUT_DOUT = 8'hC3;
      bus.test_mode    = 1'b1;
`ifdef WBR_OUT_SAFE_EN
      bus.safe_state   = 1'b0;
`endif
      #12;
      checks++; if (bus.VALID !== 1'b0) begin failures++;
         $display("FAIL reset_valid got=%b exp=0", bus.VALID); end
      checks++; if (bus.DOUT !== 8'h00) begin failures++;
         $display("FAIL reset_dout got=%h exp=00", bus.DOUT); end
      checks++; if (bus.WPSO4 !== 1'b0) begin failures++;
         $display("FAIL reset_wpso4 got=%b exp=0", bus.WPSO4); end
      checks++; if (bus.shift_done !== 1'b0) begin failures++;
         $display("FAIL reset_shift_done got=%b exp=0", bus.shift_done); end
      bus.test_mode = 1'b0;
      #1;
      checks++; if (bus.DOUT !== 8'hC3 || bus.VALID !== 1'b1) begin failures++;
         $display("FAIL reset_passthru got=%b/%h exp=1/c3", bus.VALID, bus.DOUT); end
      @(negedge CLK);
      resetn = 1'b1;
      cycle();
   endtask

   task automatic test_capture_shift();
      logic [8:0] exp_seq;
      exp_seq = 9'b1_0100_1011; // sr[8..0] after capturing A5 / VALID=1
      bus.test_mode       = 1'b1;
      bus.Core_VALID      = 1'b1;
      bus.CoreOUT_DOUT    = 8'hA5;
      bus.capture_outputs = 1'b1;
      cycle();
      idle_ctrl();
      checks++; if (bus.WPSO4 !== exp_seq[8]) begin failures++;
         $display("FAIL cap_wpso4 got=%b exp=%b", bus.WPSO4, exp_seq[8]); end
      bus.wse_outputs = 1'b1;
      bus.WPSI4       = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         cycle();
         checks++;
         if (k < 9) begin
            if (bus.WPSO4 !== exp_seq[8-k]) begin failures++;
               $display("FAIL shift%0d_wpso4 got=%b exp=%b", k, bus.WPSO4, exp_seq[8-k]); end
         end else begin
            if (bus.WPSO4 !== 1'b0) begin failures++;
               $display("FAIL shift9_wpso4 got=%b exp=0", bus.WPSO4); end
         end
         if (k == 8) begin
            checks++; if (bus.shift_done !== 1'b0) begin failures++;
               $display("FAIL shift8_done got=%b exp=0", bus.shift_done); end
         end
      end
      checks++; if (bus.shift_done !== 1'b1) begin failures++;
         $display("FAIL shift9_done got=%b exp=1", bus.shift_done); end
      // Extra shift: counter saturates.
      cycle();
      checks++; if (bus.shift_done !== 1'b1) begin failures++;
         $display("FAIL shift10_done got=%b exp=1", bus.shift_done); end
      idle_ctrl();
   endtask

   task automatic test_update();
      logic [8:0] vec;
      vec = {8'h3C, 1'b1};
      bus.test_mode   = 1'b1;
      bus.wse_outputs = 1'b1;
      for (int k = 8; k >= 0; k--) begin
         bus.WPSI4 = vec[k];
         cycle();
      end
      bus.wse_outputs = 1'b0;
      checks++; if (bus.VALID !== 1'b0 || bus.DOUT !== 8'h00) begin failures++;
         $display("FAIL pre_update got=%b/%h exp=0/00", bus.VALID, bus.DOUT); end
      bus.update_outputs = 1'b1;
      cycle();
      bus.update_outputs = 1'b0;
      checks++; if (bus.VALID !== 1'b1 || bus.DOUT !== 8'h3C) begin failures++;
         $display("FAIL post_update got=%b/%h exp=1/3c", bus.VALID, bus.DOUT); end
      // test_mode toggling leaves stored state intact.
      bus.test_mode = 1'b0;
      cycle();
      bus.test_mode = 1'b1;
      #1;
      checks++; if (bus.VALID !== 1'b1 || bus.DOUT !== 8'h3C) begin failures++;
         $display("FAIL toggle_tm got=%b/%h exp=1/3c", bus.VALID, bus.DOUT); end
      // Shift with update high: shift wins, pins hold.
      bus.wse_outputs    = 1'b1;
      bus.update_outputs = 1'b1;
      bus.WPSI4          = 1'b0;
      cycle();
      idle_ctrl();
      checks++; if (bus.VALID !== 1'b1 || bus.DOUT !== 8'h3C) begin failures++;
         $display("FAIL shift_upd_prio got=%b/%h exp=1/3c", bus.VALID, bus.DOUT); end
   endtask

   task automatic test_capture_priority();
      bus.test_mode       = 1'b1;
      bus.Core_VALID      = 1'b0;
      bus.CoreOUT_DOUT    = 8'h5A;
      bus.capture_outputs = 1'b1;
      bus.update_outputs  = 1'b1;
      cycle();
      idle_ctrl();
      checks++; if (bus.VALID !== 1'b1 || bus.DOUT !== 8'h3C) begin failures++;
         $display("FAIL cap_upd_pins got=%b/%h exp=1/3c", bus.VALID, bus.DOUT); end
      checks++; if (bus.WPSO4 !== 1'b0 || bus.shift_done !== 1'b0) begin failures++;
         $display("FAIL cap_upd_sr got=%b/%b exp=0/0", bus.WPSO4, bus.shift_done); end
      bus.update_outputs = 1'b1;
      cycle();
      idle_ctrl();
      checks++; if (bus.VALID !== 1'b0 || bus.DOUT !== 8'h5A) begin failures++;
         $display("FAIL cap_then_upd got=%b/%h exp=0/5a", bus.VALID, bus.DOUT); end
   endtask

   task automatic test_reset_mid_shift();
      bus.test_mode    = 1'b0;
      bus.Core_VALID   = 1'b1;
      bus.CoreOUT_DOUT = 8'h5A;
      #1;
      checks++; if (bus.DOUT !== 8'h5A || bus.VALID !== 1'b1) begin failures++;
         $display("FAIL passthru got=%b/%h exp=1/5a", bus.VALID, bus.DOUT); end
      bus.CoreOUT_DOUT    = 8'hFF;
      bus.capture_outputs = 1'b1;
      cycle();
      idle_ctrl();
      bus.wse_outputs = 1'b1;
      bus.WPSI4       = 1'b1;
      repeat (4) cycle();
      checks++; if (bus.WPSO4 !== 1'b1) begin failures++;
         $display("FAIL pre_rst_wpso4 got=%b exp=1", bus.WPSO4); end
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (bus.shift_done !== 1'b0 || bus.WPSO4 !== 1'b0) begin failures++;
         $display("FAIL mid_rst got=%b/%b exp=0/0", bus.shift_done, bus.WPSO4); end
      checks++; if (bus.DOUT !== 8'hFF) begin failures++;
         $display("FAIL mid_rst_passthru got=%h exp=ff", bus.DOUT); end
      bus.test_mode = 1'b1;
      #1;
      checks++; if (bus.VALID !== 1'b0 || bus.DOUT !== 8'h00) begin failures++;
         $display("FAIL mid_rst_up got=%b/%h exp=0/00", bus.VALID, bus.DOUT); end
      idle_ctrl();
      @(negedge CLK);
      resetn = 1'b1;
      // First edge after release: shift a 1 in.
      bus.wse_outputs = 1'b1;
      bus.WPSI4       = 1'b1;
      cycle();
      idle_ctrl();
      checks++; if (bus.WPSO4 !== 1'b0 || bus.shift_done !== 1'b0) begin failures++;
         $display("FAIL post_rst_shift got=%b/%b exp=0/0", bus.WPSO4, bus.shift_done); end
   endtask

`ifdef WBR_OUT_SAFE_EN
   task automatic test_safe_state();
      bus.test_mode       = 1'b1;
      bus.Core_VALID      = 1'b1;
      bus.CoreOUT_DOUT    = 8'hFF;
      bus.capture_outputs = 1'b1;
      cycle();
      idle_ctrl();
      bus.update_outputs = 1'b1;
      cycle();
      idle_ctrl();
      bus.safe_state = 1'b1;
      #1;
      checks++; if (bus.VALID !== 1'b0 || bus.DOUT !== 8'h00) begin failures++;
         $display("FAIL safe_on got=%b/%h exp=0/00", bus.VALID, bus.DOUT); end
      cycle();
      bus.safe_state = 1'b0;
      #1;
      checks++; if (bus.VALID !== 1'b1 || bus.DOUT !== 8'hFF) begin failures++;
         $display("FAIL safe_off got=%b/%h exp=1/ff", bus.VALID, bus.DOUT); end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_capture_shift();
      test_update();
      test_capture_priority();
      test_reset_mid_shift();
`ifdef WBR_OUT_SAFE_EN
      test_safe_state();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
